// File: rtl/poly_edge_assembler_if.sv
// Segment-in / polygon-out bundle for poly_edge_assembler.
// master drives segments and takes polygons; slave is the assembler.
interface poly_edge_assembler_if #(
  parameter int COORD_W   = 16,
  parameter int MAX_VERTS = 8,
  parameter int CNT_W     = $clog2(MAX_VERTS + 1)
);
  logic                         seg_valid;
  logic                         seg_ready;
  logic                         seg_accept;
  logic                         seg_last;
  logic signed [COORD_W-1:0]    seg_sx;
  logic signed [COORD_W-1:0]    seg_sy;
  logic signed [COORD_W-1:0]    seg_px;
  logic signed [COORD_W-1:0]    seg_py;
  logic                         poly_valid;
  logic                         poly_ready;
  logic [MAX_VERTS*COORD_W-1:0] poly_x;
  logic [MAX_VERTS*COORD_W-1:0] poly_y;
  logic [CNT_W-1:0]             poly_count;
  logic                         poly_ovf;

  modport master (
    output seg_valid, seg_accept, seg_last,
    output seg_sx, seg_sy, seg_px, seg_py,
    output poly_ready,
    input  seg_ready, poly_valid, poly_x, poly_y,
    input  poly_count, poly_ovf
  );

  modport slave (
    input  seg_valid, seg_accept, seg_last,
    input  seg_sx, seg_sy, seg_px, seg_py,
    input  poly_ready,
    output seg_ready, poly_valid, poly_x, poly_y,
    output poly_count, poly_ovf
  );
endinterface

// File: rtl/poly_edge_assembler.sv
// Rebuilds a closed polygon from clipped segments (COLLECT/CLOSE/OUT).
// Optional macro POLY_DEGEN_DROP_EN discards polygons with < 3 vertices.
module poly_edge_assembler #(
  parameter int COORD_W   = 16,
  parameter int MAX_VERTS = 8,
  parameter int CNT_W     = $clog2(MAX_VERTS + 1)
) (
  input logic                   clk,
  input logic                   n_rst,
  poly_edge_assembler_if.slave  bus
);
  typedef enum logic [1:0] {
    S_COLLECT,
    S_CLOSE,
    S_OUT
  } state_e;

  typedef logic signed [COORD_W-1:0] crd_t;

  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_VERTS);

  state_e           state_q;
  logic             rdy_q;
  logic             vld_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;
  crd_t             vx_q [MAX_VERTS];
  crd_t             vy_q [MAX_VERTS];

  crd_t             vx_d [MAX_VERTS];
  crd_t             vy_d [MAX_VERTS];
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cls_d;
  logic             ovf_d;
  crd_t             lx;
  crd_t             ly;
  logic             add_s;
  logic             add_p;
  logic             wrap;

  // P only needs comparing with S: S is either appended or equals the tail
  always_comb begin
    lx = '0;
    ly = '0;
    for (int i = 0; i < MAX_VERTS; i++) begin
      if (CNT_W'(i + 1) == cnt_q) begin
        lx = vx_q[i];
        ly = vy_q[i];
      end
    end
    add_s = (cnt_q == '0) || (lx != bus.seg_sx) || (ly != bus.seg_sy);
    add_p = (bus.seg_px != bus.seg_sx) || (bus.seg_py != bus.seg_sy);
    vx_d  = vx_q;
    vy_d  = vy_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (add_s) begin
      if (cnt_d == MAXC) begin
        ovf_d = 1'b1;
      end else begin
        for (int i = 0; i < MAX_VERTS; i++) begin
          if (CNT_W'(i) == cnt_d) begin
            vx_d[i] = bus.seg_sx;
            vy_d[i] = bus.seg_sy;
          end
        end
        cnt_d = cnt_d + CNT_W'(1);
      end
    end
    if (add_p) begin
      if (cnt_d == MAXC) begin
        ovf_d = 1'b1;
      end else begin
        for (int i = 0; i < MAX_VERTS; i++) begin
          if (CNT_W'(i) == cnt_d) begin
            vx_d[i] = bus.seg_px;
            vy_d[i] = bus.seg_py;
          end
        end
        cnt_d = cnt_d + CNT_W'(1);
      end
    end
    wrap  = (cnt_q >= CNT_W'(2)) && (lx == vx_q[0]) && (ly == vy_q[0]);
    cls_d = wrap ? cnt_q - CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_COLLECT;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < MAX_VERTS; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        S_COLLECT: begin
          if (bus.seg_valid) begin
            if (bus.seg_accept) begin
              vx_q  <= vx_d;
              vy_q  <= vy_d;
              cnt_q <= cnt_d;
              ovf_q <= ovf_d;
            end
            if (bus.seg_last) begin
              state_q <= S_CLOSE;
              rdy_q   <= 1'b0;
            end
          end
        end
        S_CLOSE: begin
`ifdef POLY_DEGEN_DROP_EN
          if (cls_d < CNT_W'(3)) begin
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= S_COLLECT;
            rdy_q   <= 1'b1;
          end else begin
            cnt_q   <= cls_d;
            state_q <= S_OUT;
            vld_q   <= 1'b1;
          end
`else
          cnt_q   <= cls_d;
          state_q <= S_OUT;
          vld_q   <= 1'b1;
`endif
        end
        S_OUT: begin
          if (bus.poly_ready) begin
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= S_COLLECT;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_COLLECT;
          rdy_q   <= 1'b1;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.poly_x = '0;
    bus.poly_y = '0;
    for (int i = 0; i < MAX_VERTS; i++) begin
      bus.poly_x[i*COORD_W +: COORD_W] = vx_q[i];
      bus.poly_y[i*COORD_W +: COORD_W] = vy_q[i];
    end
  end

  assign bus.seg_ready  = rdy_q;
  assign bus.poly_valid = vld_q;
  assign bus.poly_count = cnt_q;
  assign bus.poly_ovf   = ovf_q;
endmodule
